// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and a combinational instruction store.
interface fetch_unit_if;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data;

   modport master (output imem_addr, input imem_data);
   modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HALT FSM
// that stops fetching after an ECALL or EBREAK until a redirect arrives.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   fetch_unit_if.master  imem,
   output logic [31:0]   if_id_inst,
   output logic [31:0]   if_id_pc,
   output logic [31:0]   if_id_pc4,
   output logic          if_id_valid,
   output logic          halted,
   output logic          misalign,
   output logic [31:0]   pc
);

   typedef enum logic {RUN, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] ipc4_q, ipc4_d;
   logic        valid_q, valid_d;
   logic        misalign_q, misalign_d;
   logic [31:0] pc_plus4;
   logic        is_halt_inst;

   assign pc_plus4     = pc_q + 32'd4;
   assign is_halt_inst = (imem.imem_data == 32'h00000073) || (imem.imem_data == 32'h00100073);

   // Priority below reset: redirect, then stall, then halt handling, then advance.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      ipc_d      = ipc_q;
      ipc4_d     = ipc4_q;
      valid_d    = valid_q;
      misalign_d = 1'b0;
      if (redirect) begin
         pc_d       = {redirect_pc[31:2], 2'b00};
         inst_d     = NOP_INST;
         valid_d    = 1'b0;
         state_d    = RUN;
         misalign_d = |redirect_pc[1:0];
      end else if (!stall) begin
         if (state_q == HALT) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
         end else begin
            inst_d  = imem.imem_data;
            ipc_d   = pc_q;
            ipc4_d  = pc_plus4;
            valid_d = 1'b1;
            if (is_halt_inst) begin
               state_d = HALT;
            end else begin
               pc_d = pc_plus4;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         inst_q     <= NOP_INST;
         ipc_q      <= RESET_PC;
         ipc4_q     <= RESET_PC + 32'd4;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         ipc_q      <= ipc_d;
         ipc4_q     <= ipc4_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
      end
   end

   // The memory address comes straight from the PC flop so stall/redirect never reach it.
   assign imem.imem_addr = pc_q[7:2];
   assign if_id_inst     = inst_q;
   assign if_id_pc       = ipc_q;
   assign if_id_pc4      = ipc4_q;
   assign if_id_valid    = valid_q;
   assign halted         = (state_q == HALT);
   assign misalign       = misalign_q;
   assign pc             = pc_q;

endmodule
